tetris_move_sched: RTL and testbench
====================================

Name: tetris_move_sched

Overview:
- Move scheduler that sits in front of the tetris game logic and owns its move-command interface (mvL, mvR, mvD, mvRot, mvDrop).
- Arbitrates between the user button requesters and the gravity timer. Applies per-button edge detection and auto-repeat (DAS). Issues at most one one-cycle move pulse per clock, and only when the logic is not busy.

Parameters:
- GRAV_BASE, 60: ticks per gravity drop at level 0.
- GRAV_STEP, 4: ticks removed from the period per level.
- GRAV_MIN, 4: floor on the gravity period, in ticks.
- DAS_DELAY, 10: ticks from first press to first auto-repeat (L/R).
- DAS_RATE, 3: ticks between auto-repeats (L/R and soft drop).
- CNT_W, 7: width of the tick counters; must hold GRAV_BASE.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- E  in  1  game-active enable
- tick  in  1  one-cycle frame strobe (e.g. 60 Hz), synchronous to clk
- btnL, btnR, btnD, btnU, Edrop  in  1 each  debounced held-level buttons
- level  in  4  current game level
- busy  in  1  logic cannot accept a command this cycle (line clear, spawn)
- mvL, mvR, mvD, mvRot, mvDrop  out  1 each  one-cycle move pulses, mutually exclusive
- grav_pend  out  1  gravity request pending (debug/status)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low.
- Reset values: all outputs 0, all pending flags 0, all counters 0, DAS FSMs in IDLE, previous-button registers 0.
- Edge detection:
  - Each button is registered every cycle, regardless of E.
  - A press is prev=0, cur=1.
  - A button already held when E rises does not fire until it is released and pressed again.
- Pending flags: pL, pR, pD (user soft drop), pG (gravity), pU (rotate), pX (hard drop).
  - Each flag is a single bit; repeated requests while a flag is set coalesce (no queueing).
  - A flag is cleared only by its grant, or by E=0.
- Arbitration:
  - Evaluated each cycle with busy=0. Priority: pX > pU > pL/pR > (pD|pG).
  - A granted mvD clears both pD and pG.
  - Outputs are registered: a flag set at edge k is granted at edge k+1 at the earliest; the pulse lasts exactly one cycle.
  - busy=1 at an edge: no grant, all flags hold.
- Horizontal DAS FSM: states IDLE, DELAY, REPEAT; direction register dir.
  - Press of exactly one of L/R: set pL or pR, dir := that direction, counter := 0, go to DELAY.
  - DELAY: count ticks. At DAS_DELAY ticks, set the flag for dir and go to REPEAT with counter := 0.
  - REPEAT: every DAS_RATE ticks, set the flag for dir.
  - dir button released: go to IDLE. If the other button is held at that point, treat it as a new press (immediate request plus DELAY).
  - L and R both held: FSM goes IDLE and no new requests are made. Pending flags already set are still granted.
- Soft drop (btnD):
  - Press sets pD immediately.
  - While held, pD is set again every DAS_RATE ticks, with no initial delay.
- Rotate and hard drop: press only, no repeat.
- Gravity:
  - period = max(GRAV_BASE − level·GRAV_STEP, GRAV_MIN), computed unsigned with saturation. No underflow for level 15.
  - Counter increments on tick. When it reaches period−1 while tick=1: set pG, counter := 0.
  - Any granted mvD or mvDrop resets the gravity counter to 0 in the same edge.
  - A level change takes effect at the next comparison; if counter ≥ new period−1, the next tick fires.
- E=0: outputs forced 0, flags cleared, counters 0, FSMs IDLE, edge registers keep tracking.
- Simultaneous events:
  - A flag set and granted in the same cycle is resolved as a grant (the set is absorbed).
  - A gravity fire coinciding with a user mvD grant: pG is cleared by the grant and the counter resets.
- Reset mid-operation: any pulse in flight is dropped immediately (asynchronous).

Test Plan:
- Reset with buttons held, release rst, E=1 → no pulse until a button is released and re-pressed. A fresh btnL press at edge k gives mvL=1 exactly in cycle k+1, then 0.
- btnL held 20 ticks (DAS_DELAY=10, DAS_RATE=3, busy=0) → mvL count = 1 (press) + 1 (tick 10) + 3 (ticks 13, 16, 19) = 5.
- level=0, no input, 120 ticks → exactly 2 mvD pulses, 60 ticks apart. level=15 → period 4, 30 pulses in 120 ticks.
- Same cycle: Edrop, btnU and btnL pressed with busy=0 → mvDrop, then mvRot, then mvL on 3 consecutive cycles. Never two outputs high at once.
- busy held high 50 cycles while btnR is pressed and gravity fires → no pulses. On busy fall: mvR, then one mvD (pD/pG coalesced).
- Hold btnL, then release L and press R in the same cycle → mvR next cycle, DAS restarts (next mvR 10 ticks later). Holding L and R together → no further mvL/mvR pulses.

Source files
------------

// File: rtl/tetris_move_sched.sv
// Move scheduler: edge-detects buttons, applies DAS / soft-drop repeat and gravity, one move pulse per clock.
// Latency: a flag set at edge k pulses at edge k+1; busy=1 stalls every grant while pending flags hold.
module tetris_move_sched #(
  parameter int GRAV_BASE = 60,
  parameter int GRAV_STEP = 4,
  parameter int GRAV_MIN  = 4,
  parameter int DAS_DELAY = 10,
  parameter int DAS_RATE  = 3,
  parameter int CNT_W     = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       E,
  input  logic       tick,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnD,
  input  logic       btnU,
  input  logic       Edrop,
  input  logic [3:0] level,
  input  logic       busy,
  output logic       mvL,
  output logic       mvR,
  output logic       mvD,
  output logic       mvRot,
  output logic       mvDrop,
  output logic       grav_pend
);

  typedef enum logic [1:0] {H_IDLE, H_DELAY, H_REPEAT} h_state_t;

  localparam int              GW         = CNT_W + 4;
  localparam logic [GW-1:0]   BASE_W     = GW'(GRAV_BASE);
  localparam logic [GW-1:0]   MIN_W      = GW'(GRAV_MIN);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DAS_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(DAS_RATE - 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic             armed_q;
  logic [4:0]       btn, prev_q, press;
  logic             pl_q, pr_q, pd_q, pg_q, pu_q, px_q;
  logic             pl_d, pr_d, pd_d, pg_d, pu_d, px_d;
  logic             mvl_q, mvr_q, mvd_q, mvrot_q, mvdrop_q;
  h_state_t         h_state_q, h_state_d;
  logic             h_dir_q, h_dir_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, d_cnt_q, d_cnt_d, g_cnt_q, g_cnt_d;
  logic             grant_l, grant_r, grant_d, grant_u, grant_x;
  logic             set_l, set_r, set_d, set_g;
  logic             held_dir, held_oth;
  logic [GW-1:0]    grav_dec;
  logic [CNT_W-1:0] period, period_last;

  // armed_q masks the first edge after reset so buttons held through reset never count as presses
  assign btn   = {Edrop, btnU, btnD, btnR, btnL};
  assign press = btn & ~prev_q & {5{armed_q}};

  always_comb begin
    grant_x = ~busy & px_q;
    grant_u = ~busy & ~px_q & pu_q;
    grant_l = ~busy & ~px_q & ~pu_q & pl_q;
    grant_r = ~busy & ~px_q & ~pu_q & ~pl_q & pr_q;
    grant_d = ~busy & ~px_q & ~pu_q & ~pl_q & ~pr_q & (pd_q | pg_q);
  end

  always_comb begin
    grav_dec = GW'(level) * GW'(GRAV_STEP);
    if (grav_dec >= BASE_W - MIN_W) period = CNT_W'(MIN_W);
    else                            period = CNT_W'(BASE_W - grav_dec);
    period_last = period - ONE;
  end

  always_comb begin
    h_state_d = h_state_q;
    h_dir_d   = h_dir_q;
    h_cnt_d   = h_cnt_q;
    set_l     = 1'b0;
    set_r     = 1'b0;
    held_dir  = h_dir_q ? btnR : btnL;
    held_oth  = h_dir_q ? btnL : btnR;
    if (btnL && btnR) begin
      h_state_d = H_IDLE;
      h_cnt_d   = '0;
    end else if (h_state_q == H_IDLE) begin
      if (press[0] || press[1]) begin
        h_dir_d   = press[1];
        set_l     = press[0];
        set_r     = press[1];
        h_state_d = H_DELAY;
        h_cnt_d   = '0;
      end
    end else if (!held_dir) begin
      // releasing the active direction while the other is held restarts DAS the other way
      h_state_d = held_oth ? H_DELAY : H_IDLE;
      h_cnt_d   = '0;
      if (held_oth) begin
        h_dir_d = ~h_dir_q;
        set_l   = h_dir_q;
        set_r   = ~h_dir_q;
      end
    end else if (tick) begin
      if (h_cnt_q == ((h_state_q == H_DELAY) ? DELAY_LAST : RATE_LAST)) begin
        set_l     = ~h_dir_q;
        set_r     = h_dir_q;
        h_state_d = H_REPEAT;
        h_cnt_d   = '0;
      end else begin
        h_cnt_d = h_cnt_q + ONE;
      end
    end
  end

  always_comb begin
    set_d   = 1'b0;
    d_cnt_d = d_cnt_q;
    if (!btnD) begin
      d_cnt_d = '0;
    end else if (press[2]) begin
      set_d   = 1'b1;
      d_cnt_d = '0;
    end else if (tick) begin
      if (d_cnt_q == RATE_LAST) begin
        set_d   = 1'b1;
        d_cnt_d = '0;
      end else begin
        d_cnt_d = d_cnt_q + ONE;
      end
    end

    set_g   = 1'b0;
    g_cnt_d = g_cnt_q;
    if (grant_d || grant_x) begin
      g_cnt_d = '0;
    end else if (tick) begin
      if (g_cnt_q >= period_last) begin
        set_g   = 1'b1;
        g_cnt_d = '0;
      end else begin
        g_cnt_d = g_cnt_q + ONE;
      end
    end

    pl_d = ~grant_l & (pl_q | set_l);
    pr_d = ~grant_r & (pr_q | set_r);
    pd_d = ~grant_d & (pd_q | set_d);
    pg_d = ~grant_d & (pg_q | set_g);
    pu_d = ~grant_u & (pu_q | press[3]);
    px_d = ~grant_x & (px_q | press[4]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q   <= 1'b0;
      prev_q    <= '0;
      {pl_q, pr_q, pd_q, pg_q, pu_q, px_q} <= '0;
      {mvl_q, mvr_q, mvd_q, mvrot_q, mvdrop_q} <= '0;
      h_state_q <= H_IDLE;
      h_dir_q   <= 1'b0;
      h_cnt_q   <= '0;
      d_cnt_q   <= '0;
      g_cnt_q   <= '0;
    end else begin
      armed_q <= 1'b1;
      prev_q  <= btn;
      if (!E) begin
        {pl_q, pr_q, pd_q, pg_q, pu_q, px_q} <= '0;
        {mvl_q, mvr_q, mvd_q, mvrot_q, mvdrop_q} <= '0;
        h_state_q <= H_IDLE;
        h_dir_q   <= 1'b0;
        h_cnt_q   <= '0;
        d_cnt_q   <= '0;
        g_cnt_q   <= '0;
      end else begin
        {pl_q, pr_q, pd_q, pg_q, pu_q, px_q} <= {pl_d, pr_d, pd_d, pg_d, pu_d, px_d};
        {mvl_q, mvr_q, mvd_q, mvrot_q, mvdrop_q} <= {grant_l, grant_r, grant_d, grant_u, grant_x};
        h_state_q <= h_state_d;
        h_dir_q   <= h_dir_d;
        h_cnt_q   <= h_cnt_d;
        d_cnt_q   <= d_cnt_d;
        g_cnt_q   <= g_cnt_d;
      end
    end
  end

  assign mvL       = mvl_q;
  assign mvR       = mvr_q;
  assign mvD       = mvd_q;
  assign mvRot     = mvrot_q;
  assign mvDrop    = mvdrop_q;
  assign grav_pend = pg_q;

endmodule

// File: tb/tb_tetris_move_sched.sv
// Bench for tetris_move_sched: directed scenarios plus random traffic against a tick-counting reference model.
module tb_tetris_move_sched;
  localparam int GRAV_BASE = 60, GRAV_STEP = 4, GRAV_MIN = 4, DAS_DELAY = 10, DAS_RATE = 3;
  localparam int PL = 0, PR = 1, PD = 2, PG = 3, PU = 4, PX = 5;
  localparam int BL = 0, BR = 1, BD = 2, BU = 3, BX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0, E = 1'b1, tick = 1'b0, busy = 1'b0;
  logic btnL = 1'b0, btnR = 1'b0, btnD = 1'b0, btnU = 1'b0, Edrop = 1'b0;
  logic [3:0] level = 4'd0;
  logic mvL, mvR, mvD, mvRot, mvDrop, grav_pend;

  tetris_move_sched dut (
    .clk(clk), .rst(rst), .E(E), .tick(tick),
    .btnL(btnL), .btnR(btnR), .btnD(btnD), .btnU(btnU), .Edrop(Edrop),
    .level(level), .busy(busy),
    .mvL(mvL), .mvR(mvR), .mvD(mvD), .mvRot(mvRot), .mvDrop(mvDrop),
    .grav_pend(grav_pend)
  );

  always #5 clk = ~clk;

  typedef struct { int e; int c; bit gp; } exp_t;
  exp_t sbq[$];
  int   d_edges[$];
  int   checks = 0, errors = 0, edge_n = 0;
  int   cnt[6] = '{default: 0};
  int   last_edge[6] = '{default: -1};
  int   tick_per = 0, ph = 0, tick_cnt = 0;

  // reference model state: tick counts since each repeat/gravity window started
  bit   m_prev[5];
  bit   m_pend[6];
  int   h_dir, h_tk, d_tk, g_tk;

  task automatic check_eq(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int total();
    return cnt[1] + cnt[2] + cnt[3] + cnt[4] + cnt[5];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_prev[i] = 1'b1;
    for (int i = 0; i < 6; i++) m_pend[i] = 1'b0;
    h_dir = 0; h_tk = 0; d_tk = 0; g_tk = 0;
  endtask

  task automatic model_step(output int code, output bit gp);
    bit b[5], pr[5], set[6], clr[6];
    int g, nd, period;
    b = '{btnL, btnR, btnD, btnU, Edrop};
    for (int i = 0; i < 5; i++) begin
      pr[i] = b[i] && !m_prev[i];
      m_prev[i] = b[i];
    end
    if (!E) begin
      for (int i = 0; i < 6; i++) m_pend[i] = 1'b0;
      h_dir = 0; h_tk = 0; d_tk = 0; g_tk = 0;
      code = 0; gp = 1'b0;
      return;
    end
    g = 0;
    if (!busy) begin
      if (m_pend[PX]) g = 5;
      else if (m_pend[PU]) g = 4;
      else if (m_pend[PL]) g = 1;
      else if (m_pend[PR]) g = 2;
      else if (m_pend[PD] || m_pend[PG]) g = 3;
    end
    for (int i = 0; i < 6; i++) begin set[i] = 1'b0; clr[i] = 1'b0; end
    if (b[BL] && b[BR]) begin
      h_dir = 0; h_tk = 0;
    end else if (h_dir != 0 && b[h_dir - 1]) begin
      if (tick) begin
        h_tk++;
        if (h_tk == DAS_DELAY || (h_tk > DAS_DELAY && (h_tk - DAS_DELAY) % DAS_RATE == 0))
          set[h_dir - 1] = 1'b1;
      end
    end else begin
      nd = 0;
      if (h_dir != 0) nd = b[2 - h_dir] ? 3 - h_dir : 0;
      else if (pr[BL]) nd = 1;
      else if (pr[BR]) nd = 2;
      h_dir = nd; h_tk = 0;
      if (nd != 0) set[nd - 1] = 1'b1;
    end
    if (!b[BD]) d_tk = 0;
    else if (pr[BD]) begin set[PD] = 1'b1; d_tk = 0; end
    else if (tick) begin d_tk++; if (d_tk % DAS_RATE == 0) set[PD] = 1'b1; end
    period = GRAV_BASE - int'(level) * GRAV_STEP;
    if (period < GRAV_MIN) period = GRAV_MIN;
    if (g == 3 || g == 5) g_tk = 0;
    else if (tick) begin
      g_tk++;
      if (g_tk >= period) begin set[PG] = 1'b1; g_tk = 0; end
    end
    set[PU] = pr[BU];
    set[PX] = pr[BX];
    case (g)
      1: clr[PL] = 1'b1;
      2: clr[PR] = 1'b1;
      3: begin clr[PD] = 1'b1; clr[PG] = 1'b1; end
      4: clr[PU] = 1'b1;
      5: clr[PX] = 1'b1;
      default: ;
    endcase
    for (int i = 0; i < 6; i++) m_pend[i] = clr[i] ? 1'b0 : (m_pend[i] | set[i]);
    code = g;
    gp = m_pend[PG];
  endtask

  // inputs are already applied at this negedge; predict the coming edge, then advance one cycle
  task automatic cycle();
    int c; bit gp; exp_t x;
    if (!rst) model_reset();
    else begin
      model_step(c, gp);
      x.e = edge_n + 1; x.c = c; x.gp = gp;
      sbq.push_back(x);
    end
    @(negedge clk);
  endtask

  task automatic step();
    tick = (tick_per != 0) && ((ph % tick_per) == tick_per - 1);
    ph++;
    if (tick) tick_cnt++;
    cycle();
  endtask

  task automatic e_pulse();
    tick = 1'b0; E = 1'b0; cycle(); E = 1'b1;
  endtask

  initial begin : monitor
    int act, nhigh;
    exp_t x;
    forever begin
      @(posedge clk); #1;
      edge_n++;
      nhigh = int'(mvL) + int'(mvR) + int'(mvD) + int'(mvRot) + int'(mvDrop);
      act = mvDrop ? 5 : mvRot ? 4 : mvD ? 3 : mvR ? 2 : mvL ? 1 : 0;
      if (!rst) begin
        check_eq("reset_quiet", nhigh + int'(grav_pend), 0);
      end else begin
        check_eq("one_hot", int'(nhigh > 1), 0);
        if (sbq.size() == 0) begin
          check_eq("scoreboard_has_entry", 0, 1);
        end else begin
          x = sbq.pop_front();
          checks++;
          if (x.e != edge_n || x.c != act || x.gp != grav_pend) begin
            errors++;
            $display("FAIL scoreboard edge %0d: got move %0d grav_pend %0d, expected move %0d grav_pend %0d (entry edge %0d)",
                     edge_n, act, grav_pend, x.c, x.gp, x.e);
          end
        end
      end
      if (act != 0) begin
        cnt[act]++;
        last_edge[act] = edge_n;
        if (act == 3) d_edges.push_back(edge_n);
      end
    end
  end

  initial begin : stimulus
    int base, base2, k, t0, tick_edge, di;
    model_reset();
    @(negedge clk);

    // reset with buttons held: nothing fires until a release/re-press
    rst = 1'b0; E = 1'b1; btnL = 1'b1; btnU = 1'b1; Edrop = 1'b1; tick = 1'b0;
    cycle(); cycle();
    check_eq("reset_outputs", int'({mvL, mvR, mvD, mvRot, mvDrop, grav_pend}), 0);
    rst = 1'b1;
    base = total();
    repeat (10) cycle();
    check_eq("held_through_reset_silent", total() - base, 0);
    btnL = 1'b0; cycle();
    btnL = 1'b1; k = edge_n + 1; base = cnt[1];
    cycle(); repeat (3) cycle();
    check_eq("first_mvL_edge", last_edge[1], k + 1);
    check_eq("first_mvL_count", cnt[1] - base, 1);
    btnL = 1'b0; btnU = 1'b0; Edrop = 1'b0; cycle();

    // DAS: btnL held for 20 ticks
    tick_per = 4; e_pulse();
    btnL = 1'b1; tick = 1'b0; base = cnt[1]; cycle();
    t0 = tick_cnt;
    while (tick_cnt - t0 < 20) step();
    btnL = 1'b0; tick = 1'b0; repeat (3) cycle();
    check_eq("das_20_ticks_mvL", cnt[1] - base, 5);

    // gravity at level 0 and level 15
    tick_per = 3; level = 4'd0; e_pulse();
    base = cnt[3]; di = d_edges.size(); t0 = tick_cnt;
    while (tick_cnt - t0 < 120) step();
    tick = 1'b0; repeat (3) cycle();
    check_eq("grav_l0_count", cnt[3] - base, 2);
    if (d_edges.size() >= di + 2) check_eq("grav_l0_spacing", d_edges[di + 1] - d_edges[di], 60 * 3);
    else check_eq("grav_l0_spacing_present", d_edges.size() - di, 2);
    level = 4'd15; e_pulse();
    base = cnt[3]; t0 = tick_cnt;
    while (tick_cnt - t0 < 120) step();
    tick = 1'b0; repeat (3) cycle();
    check_eq("grav_l15_count", cnt[3] - base, 30);

    // simultaneous hard drop, rotate, left
    level = 4'd0; e_pulse();
    Edrop = 1'b1; btnU = 1'b1; btnL = 1'b1; tick = 1'b0; k = edge_n + 1;
    cycle(); repeat (4) cycle();
    check_eq("prio_drop_edge", last_edge[5], k + 1);
    check_eq("prio_rot_edge", last_edge[4], k + 2);
    check_eq("prio_left_edge", last_edge[1], k + 3);
    Edrop = 1'b0; btnU = 1'b0; btnL = 1'b0; cycle();

    // busy window with right press, soft drop and gravity all coalescing
    level = 4'd15; tick_per = 2; e_pulse();
    busy = 1'b1; btnR = 1'b1; btnD = 1'b1; base = total();
    for (int i = 0; i < 50; i++) begin
      if (i == 3) begin btnR = 1'b0; btnD = 1'b0; end
      step();
    end
    check_eq("busy_no_pulses", total() - base, 0);
    check_eq("busy_grav_pend", int'(grav_pend), 1);
    busy = 1'b0; tick = 1'b0; tick_per = 0; k = edge_n + 1; base = cnt[2]; base2 = cnt[3];
    repeat (4) cycle();
    check_eq("busy_release_mvR_edge", last_edge[2], k);
    check_eq("busy_release_mvD_edge", last_edge[3], k + 1);
    check_eq("busy_release_mvD_count", cnt[3] - base2, 1);
    check_eq("busy_release_mvR_count", cnt[2] - base, 1);

    // direction switch restarts DAS; both held goes quiet
    level = 4'd0; tick_per = 3; e_pulse();
    btnL = 1'b1; tick = 1'b0; cycle();
    repeat (7) step();
    btnL = 1'b0; btnR = 1'b1; tick = 1'b0; k = edge_n + 1; base = cnt[2];
    cycle(); cycle();
    check_eq("switch_mvR_edge", last_edge[2], k + 1);
    t0 = tick_cnt;
    while (tick_cnt - t0 < 10) step();
    tick_edge = edge_n;
    tick = 1'b0; cycle(); cycle();
    check_eq("switch_das_restart_edge", last_edge[2], tick_edge + 1);
    check_eq("switch_mvR_count", cnt[2] - base, 2);
    btnL = 1'b1; tick = 1'b0; cycle(); cycle();
    base = cnt[1] + cnt[2];
    repeat (60) step();
    check_eq("both_held_quiet", cnt[1] + cnt[2] - base, 0);
    btnL = 1'b0; btnR = 1'b0; tick = 1'b0; cycle();

    // random traffic, including E drops, level changes and async resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) btnL = ~btnL;
      if ($urandom_range(0, 7) == 0) btnR = ~btnR;
      if ($urandom_range(0, 7) == 0) btnD = ~btnD;
      if ($urandom_range(0, 9) == 0) btnU = ~btnU;
      if ($urandom_range(0, 9) == 0) Edrop = ~Edrop;
      busy = ($urandom_range(0, 3) == 0);
      tick = ($urandom_range(0, 2) == 0);
      if (E && $urandom_range(0, 199) == 0) E = 1'b0;
      else if (!E && $urandom_range(0, 9) == 0) E = 1'b1;
      if ($urandom_range(0, 99) == 0) level = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b0; cycle(); rst = 1'b1;
      end
      cycle();
    end

    check_eq("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
